// File: rtl/power_pulse_sched_if.sv
// Pulse-scheduler bus: CPU config/control on one side, generator drive/feedback on the other.
// Latency: wires only, no storage.
// Backpressure: none; every strobe is a single-cycle command that is always accepted.
interface power_pulse_sched_if #(
  parameter int CNT_W = 32
);
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_count;
  logic             cfg_wr;
  logic             start;
  logic             stop;
  logic             pulse_in;
  logic [CNT_W-1:0] gen_width;
  logic             gen_enable;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic [CNT_W-1:0] pulses_done;

  modport master (
    output cfg_width, cfg_count, cfg_wr, start, stop, pulse_in,
    input  gen_width, gen_enable, busy, done, cfg_err, pulses_done
  );

  modport slave (
    input  cfg_width, cfg_count, cfg_wr, start, stop, pulse_in,
    output gen_width, gen_enable, busy, done, cfg_err, pulses_done
  );
endinterface

// File: rtl/power_pulse_sched.sv
// Shadows CPU pulse config and sequences the pulse generator (continuous or N-pulse burst).
// Latency: every output is registered; reacts one clkin after the command or pulse_in edge.
// Backpressure: none; width changes wait for a pulse_in edge, stop waits for the high phase to end.
module power_pulse_sched #(
  parameter int CNT_W     = 32,
  parameter int MIN_WIDTH = 2
) (
  input logic                clkin,
  input logic                rst_n,
  power_pulse_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] shadow_width;
  logic [CNT_W-1:0] shadow_count;
  logic [CNT_W-1:0] burst_count;
  logic [CNT_W-1:0] gen_width_q;
  logic [CNT_W-1:0] pulses_done_q;
  logic             pend;
  logic             pulse_prev;
  logic             done_q;
  logic             cfg_err_q;

  logic rise;
  logic fall;
  logic width_ok;
  logic burst_last;
  logic accept;
  logic reject;
  logic apply;
  logic count_fall;
  logic done_nxt;

  assign rise       = ~pulse_prev & bus.pulse_in;
  assign fall       = pulse_prev & ~bus.pulse_in;
  assign width_ok   = (shadow_width >= MIN_W);
  // The fall now being seen is the last one of a finite burst.
  assign burst_last = (burst_count != '0) && (pulses_done_q == burst_count - ONE);

  // State register.
  always_ff @(posedge clkin) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Sequencing decisions: start accept/reject, width apply, fall counting, stop handling.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    reject     = 1'b0;
    apply      = 1'b0;
    count_fall = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          if (width_ok) begin
            accept    = 1'b1;
            state_nxt = RUN;
          end else begin
            reject = 1'b1;
          end
        end
      end
      RUN: begin
        // A write landing on the edge wins; its value goes out on the following edge.
        apply      = (rise | fall) && pend && !bus.cfg_wr && width_ok;
        count_fall = fall;
        if (fall && burst_last) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (bus.stop) begin
          // Never chop a high phase: if high, let it finish first.
          state_nxt = bus.pulse_in ? STOPPING : IDLE;
        end
      end
      STOPPING: begin
        if (fall) begin
          count_fall = 1'b1;
          done_nxt   = burst_last;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow registers, generator width, pulse counter and one-cycle status pulses.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      shadow_width  <= '0;
      shadow_count  <= '0;
      burst_count   <= '0;
      gen_width_q   <= '0;
      pulses_done_q <= '0;
      pend          <= 1'b0;
      pulse_prev    <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      pulse_prev <= bus.pulse_in;
      done_q     <= done_nxt;
      cfg_err_q  <= reject;
      if (accept) begin
        gen_width_q   <= shadow_width;
        burst_count   <= shadow_count;
        pulses_done_q <= '0;
      end else if (apply) begin
        gen_width_q <= shadow_width;
      end
      if (count_fall && (pulses_done_q != ALL_ONES)) begin
        pulses_done_q <= pulses_done_q + ONE;
      end
      if (bus.cfg_wr) begin
        shadow_width <= bus.cfg_width;
        shadow_count <= bus.cfg_count;
        pend         <= 1'b1;
      end else if (accept || apply) begin
        pend <= 1'b0;
      end
    end
  end

  assign bus.gen_width   = gen_width_q;
  assign bus.gen_enable  = (state != IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.pulses_done = pulses_done_q;

endmodule

// File: tb/tb_power_pulse_sched.sv
// Bench for power_pulse_sched: directed scenarios plus randomized commands against a behavioural model.
// Latency: a bench-side pulse generator closes the loop from gen_width/gen_enable back to pulse_in.
// Backpressure: not applicable; all DUT inputs are single-cycle strobes.
module tb_power_pulse_sched;
  localparam int CNT_W = 32;

  logic clkin = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  power_pulse_sched_if #(.CNT_W(CNT_W)) bus ();

  power_pulse_sched #(.CNT_W(CNT_W), .MIN_WIDTH(2)) dut (
    .clkin (clkin),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Pulse generator: each phase lasts gen_width cycles, first high phase right after enable.
  logic [31:0] gen_cnt = 0;
  always @(posedge clkin) begin
    if (bus.gen_enable !== 1'b1) begin
      bus.pulse_in <= 1'b0;
      gen_cnt      <= 0;
    end else if (gen_cnt == 0) begin
      bus.pulse_in <= 1'b1;
      gen_cnt      <= 1;
    end else if (gen_cnt >= bus.gen_width) begin
      bus.pulse_in <= ~bus.pulse_in;
      gen_cnt      <= 1;
    end else begin
      gen_cnt <= gen_cnt + 1;
    end
  end

  // Behavioural reference: what the outputs must be after each clkin edge.
  logic        m_valid = 1'b0;
  logic        m_run, m_drain, m_pend, m_prev, m_done, m_err;
  logic        m_rose, m_fell, m_was_drain, m_finished;
  logic [31:0] m_sw, m_sc, m_gw, m_bc, m_pd;
  always @(posedge clkin) begin
    if (!rst_n) begin
      m_run = 0; m_drain = 0; m_pend = 0; m_prev = 0; m_done = 0; m_err = 0;
      m_sw = 0; m_sc = 0; m_gw = 0; m_bc = 0; m_pd = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_rose = !m_prev && bus.pulse_in;
      m_fell = m_prev && !bus.pulse_in;
      m_done = 0;
      m_err  = 0;
      if (!m_run) begin
        if (bus.start && !bus.stop) begin
          if (m_sw >= 2) begin
            m_gw = m_sw; m_bc = m_sc; m_pd = 0; m_pend = 0; m_run = 1; m_drain = 0;
          end else begin
            m_err = 1;
          end
        end
      end else begin
        m_was_drain = m_drain;
        m_finished  = 0;
        if (!m_was_drain && (m_rose || m_fell) && m_pend && !bus.cfg_wr && m_sw >= 2) begin
          m_gw   = m_sw;
          m_pend = 0;
        end
        if (m_fell) begin
          if (m_pd != 32'hFFFF_FFFF) m_pd = m_pd + 1;
          if (m_bc != 0 && m_pd == m_bc) begin
            m_done     = 1;
            m_finished = 1;
          end
          if (m_was_drain) m_finished = 1;
        end
        if (m_finished) begin
          m_run = 0; m_drain = 0;
        end else if (!m_was_drain && bus.stop) begin
          if (bus.pulse_in) m_drain = 1;
          else              m_run = 0;
        end
      end
      if (bus.cfg_wr) begin
        m_sw = bus.cfg_width; m_sc = bus.cfg_count; m_pend = 1;
      end
      m_prev = bus.pulse_in;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clkin) begin
    if (m_valid) begin
      check("gen_width",   bus.gen_width, m_gw);
      check("gen_enable",  32'(bus.gen_enable), 32'(m_run));
      check("busy",        32'(bus.busy), 32'(m_run));
      check("done",        32'(bus.done), 32'(m_done));
      check("cfg_err",     32'(bus.cfg_err), 32'(m_err));
      check("pulses_done", bus.pulses_done, m_pd);
    end
  end

  // Phase-length and done-pulse recorder.
  int   n_done = 0;
  int   hi_len = 0;
  int   lo_len = 0;
  logic lo_armed = 1'b0;
  int   hq[$];
  int   lq[$];
  always @(negedge clkin) begin
    if (bus.done === 1'b1) n_done++;
    if (bus.pulse_in === 1'b1) begin
      if (lo_armed) begin
        lq.push_back(lo_len);
        lo_armed = 1'b0;
      end
      hi_len++;
      lo_len = 0;
    end else begin
      if (hi_len != 0) begin
        hq.push_back(hi_len);
        lo_armed = 1'b1;
      end
      hi_len = 0;
      lo_len++;
    end
  end

  task automatic cfg(input int w, input int c);
    bus.cfg_width = w;
    bus.cfg_count = c;
    bus.cfg_wr    = 1'b1;
    @(negedge clkin);
    bus.cfg_wr = 1'b0;
  endtask

  task automatic strobe_start();
    bus.start = 1'b1;
    @(negedge clkin);
    bus.start = 1'b0;
  endtask

  task automatic strobe_stop();
    bus.stop = 1'b1;
    @(negedge clkin);
    bus.stop = 1'b0;
  endtask

  task automatic wait_pin(input logic lvl, input string name);
    int i = 0;
    while (bus.pulse_in !== lvl && i < 200) begin
      @(negedge clkin);
      i++;
    end
    if (bus.pulse_in !== lvl) timeout_fail(name);
  endtask

  task automatic wait_idle(input string name);
    int i = 0;
    while (bus.busy !== 1'b0 && i < 300) begin
      @(negedge clkin);
      i++;
    end
    if (bus.busy !== 1'b0) timeout_fail(name);
  endtask

  int nh0, nd0, ls0, mn;

  initial begin
    bus.cfg_width = 0; bus.cfg_count = 0; bus.cfg_wr = 0; bus.start = 0; bus.stop = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clkin);
    check("rst_gen_width",   bus.gen_width, 0);
    check("rst_gen_enable",  32'(bus.gen_enable), 0);
    check("rst_busy",        32'(bus.busy), 0);
    check("rst_pulses_done", bus.pulses_done, 0);
    rst_n = 1'b1;
    @(negedge clkin);

    // Burst of 3 at width 5.
    cfg(5, 3);
    strobe_start();
    check("t1_enable_t1", 32'(bus.gen_enable), 1);
    check("t1_busy_t1",   32'(bus.busy), 1);
    check("t1_width",     bus.gen_width, 5);
    nh0 = hq.size();
    nd0 = n_done;
    wait_idle("t1_idle");
    check("t1_done_at_end", 32'(bus.done), 1);
    check("t1_pulses_done", bus.pulses_done, 3);
    check("t1_model_pd",    m_pd, 3);
    check("t1_high_phases", 32'(hq.size() - nh0), 3);
    check("t1_high_len",    32'(hq[hq.size()-1]), 5);
    @(negedge clkin);
    check("t1_done_once",   32'(n_done - nd0), 1);
    check("t1_enable_off",  32'(bus.gen_enable), 0);

    // Continuous width 4, write 8 in the middle of a high phase.
    cfg(4, 0);
    strobe_start();
    wait_pin(1'b1, "t2_rise");
    nh0 = hq.size();
    ls0 = lq.size();
    @(negedge clkin);
    cfg(8, 0);
    check("t2_width_hold", bus.gen_width, 4);
    wait_pin(1'b0, "t2_fall");
    @(negedge clkin);
    check("t2_width_new", bus.gen_width, 8);
    repeat (40) @(negedge clkin);
    mn = 1000;
    for (int i = nh0; i < hq.size(); i++) if (hq[i] < mn) mn = hq[i];
    for (int i = ls0; i < lq.size(); i++) if (lq[i] < mn) mn = lq[i];
    check("t2_no_short_phase", 32'(mn >= 4), 1);
    check("t2_first_high",     32'(hq[nh0]), 4);
    check("t2_later_high",     32'(hq[hq.size()-1]), 8);
    strobe_stop();
    wait_idle("t2_idle");
    @(negedge clkin);

    // Write coinciding with the rise: applied at the next edge, not this one.
    cfg(4, 0);
    strobe_start();
    wait_pin(1'b1, "t6_rise");
    cfg(6, 0);
    check("t6_width_on_edge", bus.gen_width, 4);
    @(negedge clkin);
    check("t6_width_still",   bus.gen_width, 4);
    wait_pin(1'b0, "t6_fall");
    @(negedge clkin);
    check("t6_width_next",    bus.gen_width, 6);
    strobe_stop();
    wait_idle("t6_idle");
    @(negedge clkin);

    // Stop during a high phase of width 6.
    cfg(6, 0);
    strobe_start();
    wait_pin(1'b1, "t3_rise");
    repeat (2) @(negedge clkin);
    nd0 = n_done;
    strobe_stop();
    check("t3_stopping_busy",   32'(bus.busy), 1);
    check("t3_stopping_enable", 32'(bus.gen_enable), 1);
    wait_idle("t3_idle");
    check("t3_last_high", 32'(hq[hq.size()-1]), 6);
    check("t3_no_done",   32'(n_done - nd0), 0);
    @(negedge clkin);

    // Rejected start, and start+stop together.
    cfg(1, 0);
    strobe_start();
    check("t4_cfg_err",  32'(bus.cfg_err), 1);
    check("t4_busy",     32'(bus.busy), 0);
    check("t4_enable",   32'(bus.gen_enable), 0);
    @(negedge clkin);
    check("t4_err_once", 32'(bus.cfg_err), 0);
    cfg(5, 0);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clkin);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("t4_ss_busy", 32'(bus.busy), 0);
    check("t4_ss_err",  32'(bus.cfg_err), 0);

    // Reset in the middle of a burst clears shadows too.
    cfg(5, 10);
    strobe_start();
    repeat (20) @(negedge clkin);
    rst_n = 1'b0;
    @(negedge clkin);
    rst_n = 1'b1;
    check("t5_width",   bus.gen_width, 0);
    check("t5_enable",  32'(bus.gen_enable), 0);
    check("t5_busy",    32'(bus.busy), 0);
    check("t5_done",    32'(bus.done), 0);
    check("t5_pulses",  bus.pulses_done, 0);
    strobe_start();
    check("t5_reject",  32'(bus.cfg_err), 1);
    check("t5_no_busy", 32'(bus.busy), 0);

    // Randomized commands, checked every cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      bus.cfg_wr    = ($urandom_range(0, 11) == 0);
      bus.cfg_width = $urandom_range(0, 7);
      bus.cfg_count = $urandom_range(0, 4);
      bus.start     = ($urandom_range(0, 9) == 0);
      bus.stop      = ($urandom_range(0, 39) == 0);
      rst_n         = ($urandom_range(0, 399) != 0);
      @(negedge clkin);
    end
    bus.cfg_wr = 0; bus.start = 0; bus.stop = 0; rst_n = 1'b1;
    repeat (5) @(negedge clkin);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
